dmem_responder: RTL and testbench

// - Memory-side responder for the pipeline's data-memory port: accepts one load/store request at a time

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_ram.sv | 36 +++
 rtl/dmem_responder.sv | 187 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: state encoding, counter width and the
// address-window check used at request acceptance.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned CNT_W = 4;

  // True when addr lies in [base, base + 4*2^depth_log2). Computed in 33 bits so a window that
  // ends exactly at 2^32 does not wrap.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned depth_log2);
    logic [32:0] lo;
    logic [32:0] hi;
    logic [32:0] a;
    lo = {1'b0, base};
    a  = {1'b0, addr};
    hi = lo + (33'd1 << (depth_log2 + 2));
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables. Read and write share one
// access cycle; the read port returns the word as it was before the write.
module dmem_ram #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  logic [31:0] mem [Words];
  logic [31:0] rdata_q;

  // Byte-masked write and registered read on every enabled cycle; no reset on contents.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Latency-accurate data-memory target: accepts one load/store at a time, waits a fixed number
// of cycles, performs the access and holds the response until the requester takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  // With LATENCY=1 the access happens on the accepting edge itself, straight from the inputs.
  localparam bit DirectAccess = (LATENCY == 1);
  // The counter holds the number of further WAIT cycles after the current one, so WAIT spans
  // LATENCY-1 cycles in total.
  localparam logic [CNT_W-1:0] CntLoad = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_load_q, rsp_load_d;

  logic                  accept;
  logic                  rsp_take;
  logic                  req_err;
  logic [31:0]           req_off;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  access;
  logic                  a_we;
  logic [3:0]            a_be;
  logic [31:0]           a_wdata;
  logic [DEPTH_LOG2-1:0] a_idx;
  logic                  a_err;
  logic [31:0]           ram_rdata;

  // Request decode: handshake, error classification and word index from the live inputs.
  always_comb begin
    accept   = req_valid && (state_q == ST_IDLE);
    rsp_take = (state_q == ST_RESP) && rsp_ready;
    req_err  = (req_addr[1:0] != 2'b00) || !addr_in_window(req_addr, BASE_ADDR, DEPTH_LOG2);
    req_off  = req_addr - BASE_ADDR;
    req_idx  = DEPTH_LOG2'(req_off >> 2);
  end

  // Access strobe and operand select: live inputs when accessing on the accept edge, else latched.
  always_comb begin
    access = !rst && (((state_q == ST_WAIT) && (cnt_q == '0)) || (DirectAccess && accept));
    if (state_q == ST_IDLE) begin
      a_we    = req_we;
      a_be    = req_be;
      a_wdata = req_wdata;
      a_idx   = req_idx;
      a_err   = req_err;
    end else begin
      a_we    = we_q;
      a_be    = be_q;
      a_wdata = wdata_q;
      a_idx   = idx_q;
      a_err   = err_q;
    end
  end

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      rsp_err_q  <= rsp_err_d;
      rsp_load_q <= rsp_load_d;
    end
  end

  // Next-state logic and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (DirectAccess) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CntLoad;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request latch on acceptance; response flags set on the access edge, cleared on handshake.
  always_comb begin
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    err_d      = err_q;
    rsp_err_d  = rsp_err_q;
    rsp_load_d = rsp_load_q;
    if (accept) begin
      we_d    = req_we;
      be_d    = req_be;
      wdata_d = req_wdata;
      idx_d   = req_idx;
      err_d   = req_err;
    end
    if (access) begin
      rsp_err_d  = a_err;
      rsp_load_d = !a_we && !a_err;
    end else if (rsp_take) begin
      rsp_err_d  = 1'b0;
      rsp_load_d = 1'b0;
    end
  end

  // Output decode; read data only passes through for a successful load in RESP.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_err   = rsp_err_q;
    rsp_rdata = rsp_load_q ? ram_rdata : 32'h0;
  end

  // Errored stores are masked here so they never touch the array.
  dmem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .en   (access),
    .we   (a_we && !a_err),
    .be   (a_be),
    .addr (a_idx),
    .wdata(a_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance for reset, latency, byte-enable,
// error and backpressure steps, and one LATENCY=1 instance for back-to-back traffic.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  logic        req_valid_b = 1'b0;
  logic        req_ready_b;
  logic        req_we_b = 1'b0;
  logic [31:0] req_addr_b = 32'h0;
  logic [3:0]  req_be_b = 4'h0;
  logic [31:0] req_wdata_b = 32'h0;
  logic        rsp_valid_b;
  logic [31:0] rsp_rdata_b;
  logic        rsp_err_b;
  logic        busy_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(
    .DEPTH_LOG2(10),
    .LATENCY   (2),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_be   (req_be),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  dmem_responder #(
    .DEPTH_LOG2(10),
    .LATENCY   (1),
    .BASE_ADDR (32'h0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid_b),
    .req_ready(req_ready_b),
    .req_we   (req_we_b),
    .req_addr (req_addr_b),
    .req_be   (req_be_b),
    .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b),
    .rsp_ready(1'b1),
    .rsp_rdata(rsp_rdata_b),
    .rsp_err  (rsp_err_b),
    .busy     (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance A from IDLE with rsp_ready high. lat is the edge index,
  // counted from the accepting edge, at which a rising-edge sampler first sees rsp_valid.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    if (!rsp_valid) begin
      n_vec++;
      n_err++;
      $error("FAIL rsp_timeout: observed no rsp_valid, expected one within 20 cycles");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          last_cyc;
    logic [31:0] data;

    // Power-on reset
    #2 rst = 1'b1;
    #1;
    check("por_req_ready", 32'(req_ready), 32'd1);
    check("por_rsp_valid", 32'(rsp_valid), 32'd0);
    check("por_rsp_rdata", rsp_rdata, 32'h0);
    check("por_rsp_err", 32'(rsp_err), 32'd0);
    check("por_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset during WAIT of a store drops it
    run_req(1'b1, 32'h10, 4'hF, 32'h5555AAAA, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_req_ready", 32'(req_ready), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_async_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_async_rsp_err", 32'(rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_req(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    check("rst_load_0x10", rd, 32'h5555AAAA);

    // Basic latency
    run_req(1'b1, 32'h40, 4'hF, 32'h12345678, rd, er, lat);
    check("lat_store_edges", 32'(lat), 32'd2);
    check("lat_store_rdata", rd, 32'h0);
    check("lat_store_err", 32'(er), 32'd0);
    run_req(1'b0, 32'h40, 4'h0, 32'h0, rd, er, lat);
    check("lat_load_edges", 32'(lat), 32'd2);
    check("lat_load_rdata", rd, 32'h12345678);
    check("lat_load_err", 32'(er), 32'd0);

    // Byte enables, including an all-zero mask
    run_req(1'b1, 32'h80, 4'hF, 32'hAABBCCDD, rd, er, lat);
    run_req(1'b1, 32'h80, 4'b0101, 32'h11223344, rd, er, lat);
    run_req(1'b0, 32'h80, 4'h0, 32'h0, rd, er, lat);
    check("be_0101_rdata", rd, 32'hAA22CC44);
    run_req(1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, rd, er, lat);
    check("be_0000_err", 32'(er), 32'd0);
    run_req(1'b0, 32'h40, 4'h0, 32'h0, rd, er, lat);
    check("be_0000_unchanged", rd, 32'h12345678);

    // Errors: misaligned, out of range, top word intact
    run_req(1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D, rd, er, lat);
    run_req(1'b0, 32'h42, 4'h0, 32'h0, rd, er, lat);
    check("err_misal_load_err", 32'(er), 32'd1);
    check("err_misal_load_rdata", rd, 32'h0);
    check("err_misal_load_edges", 32'(lat), 32'd2);
    run_req(1'b1, 32'h1000, 4'hF, 32'h12121212, rd, er, lat);
    check("err_oor_store_err", 32'(er), 32'd1);
    check("err_oor_store_rdata", rd, 32'h0);
    run_req(1'b1, 32'h41, 4'hF, 32'h34343434, rd, er, lat);
    check("err_misal_store_err", 32'(er), 32'd1);
    run_req(1'b0, 32'hFFC, 4'h0, 32'h0, rd, er, lat);
    check("err_last_word", rd, 32'hCAFEF00D);
    check("err_last_word_err", 32'(er), 32'd0);
    run_req(1'b0, 32'h0, 4'h0, 32'h0, rd, er, lat);
    check("err_oor_no_wrap", rd === 32'h12121212 ? 32'd1 : 32'd0, 32'd0);
    run_req(1'b0, 32'h40, 4'h0, 32'h0, rd, er, lat);
    check("err_misal_no_write", rd, 32'h12345678);

    // Backpressure: response held for 5 cycles, new request fields ignored
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h80;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hAA22CC44);
      check("bp_rsp_err", 32'(rsp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_req_ready", 32'(req_ready), 32'd1);
    check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_rsp_rdata", rsp_rdata, 32'h0);
    check("bp_release_busy", 32'(busy), 32'd0);
    run_req(1'b0, 32'h80, 4'h0, 32'h0, rd, er, lat);
    check("bp_ignored_store", rd, 32'hAA22CC44);

    // Back-to-back on the LATENCY=1 instance with rsp_ready tied high
    req_valid_b = 1'b1;
    last_cyc = 0;
    for (int j = 0; j < 16; j++) begin
      data = 32'h10000001 + 32'(j / 2) * 32'h00112233;
      req_we_b    = (j % 2 == 0);
      req_addr_b  = 32'h100 + 32'(4 * (j / 2));
      req_be_b    = 4'hF;
      req_wdata_b = (j % 2 == 0) ? data : 32'hFFFFFFFF;
      check("b2b_ready", 32'(req_ready_b), 32'd1);
      @(posedge clk); #1;
      check("b2b_rsp_valid", 32'(rsp_valid_b), 32'd1);
      check("b2b_busy", 32'(busy_b), 32'd1);
      check("b2b_rsp_err", 32'(rsp_err_b), 32'd0);
      check("b2b_rsp_rdata", rsp_rdata_b, (j % 2 == 0) ? 32'h0 : data);
      if (j > 0) begin
        check("b2b_spacing", 32'(cyc - last_cyc), 32'd2);
      end
      last_cyc = cyc;
      @(posedge clk); #1;
    end
    req_valid_b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
